// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: shared types for alu_mdu_ctrl.
//   ctrl_e       4-bit operation code driven on the ctrl output
//   F_*          MIPS R-type funct field values
//   state_e      sequencing states (IDLE / MUL / DIV)
//   decode_ctrl  alu_op + funct -> ctrl_e
package alu_mdu_pkg;

  typedef enum logic [3:0] {
    CTRL_AND   = 4'b0000,
    CTRL_OR    = 4'b0001,
    CTRL_ADD   = 4'b0010,
    CTRL_XOR   = 4'b0011,
    CTRL_SUB   = 4'b0110,
    CTRL_SLT   = 4'b0111,
    CTRL_SLTU  = 4'b1000,
    CTRL_MULT  = 4'b1001,
    CTRL_MULTU = 4'b1010,
    CTRL_DIV   = 4'b1011,
    CTRL_NOR   = 4'b1100,
    CTRL_DIVU  = 4'b1101,
    CTRL_MFHI  = 4'b1110,
    CTRL_MFLO  = 4'b1111
  } ctrl_e;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  // alu_op 11 and unknown funct values fall back to AND.
  function automatic ctrl_e decode_ctrl(input logic [1:0] alu_op, input logic [5:0] funct);
    ctrl_e c;
    c = CTRL_AND;
    case (alu_op)
      2'b00: c = CTRL_ADD;
      2'b01: c = CTRL_SUB;
      2'b10: begin
        case (funct)
          F_ADD, F_ADDU: c = CTRL_ADD;
          F_SUB, F_SUBU: c = CTRL_SUB;
          F_AND:         c = CTRL_AND;
          F_OR:          c = CTRL_OR;
          F_XOR:         c = CTRL_XOR;
          F_NOR:         c = CTRL_NOR;
          F_SLT:         c = CTRL_SLT;
          F_SLTU:        c = CTRL_SLTU;
          F_MULT:        c = CTRL_MULT;
          F_MULTU:       c = CTRL_MULTU;
          F_DIV:         c = CTRL_DIV;
          F_DIVU:        c = CTRL_DIVU;
          F_MFHI:        c = CTRL_MFHI;
          F_MFLO:        c = CTRL_MFLO;
          default:       c = CTRL_AND;
        endcase
      end
      default: c = CTRL_AND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply / divide datapath with its step counter.
//   load       capture operand magnitudes and sign info (start accepted)
//   run        perform one step per cycle (owner FSM is busy)
//   is_div     1 = restoring divide, 0 = shift-add multiply
//   is_signed  treat a/b as two's complement and sign-correct the result
//   last       high during the final step; hi/lo hold the finished values
//   hi, lo     combinational final HI/LO, meaningful only while last=1
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  // acc holds {upper, lower}: product/multiplier for MUL, remainder/quotient for DIV.
  logic [2*WIDTH-1:0] acc_q, acc_d, step, prod;
  logic [WIDTH-1:0]   opb_q, opb_d, a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, dz_q, dz_d;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;

  always_comb begin
    mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    // Remainder after a successful subtract is below the divisor, so bit WIDTH is the borrow.
    if (div_q) begin
      step = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                             : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
    end else begin
      step = {mul_sum, acc_q[WIDTH-1:1]};
    end

    acc_d    = acc_q;
    opb_d    = opb_q;
    a_raw_d  = a_raw_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    if (load) begin
      acc_d    = {{WIDTH{1'b0}}, mag_a};
      opb_d    = mag_b;
      a_raw_d  = a;
      cnt_d    = '0;
      div_d    = is_div;
      neg_lo_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_hi_d = is_signed & is_div & a[WIDTH-1];
      dz_d     = (b == '0);
    end else if (run) begin
      acc_d = step;
      cnt_d = cnt_q + 1'b1;
    end

    // Results are taken from the final step so HI/LO land on the last run edge.
    prod = neg_lo_q ? -step : step;
    quo  = neg_lo_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    rem  = neg_hi_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    if (!div_q) begin
      hi = prod[2*WIDTH-1:WIDTH];
      lo = prod[WIDTH-1:0];
    end else if (dz_q) begin
      hi = a_raw_q;
      lo = '1;
    end else begin
      hi = rem;
      lo = quo;
    end
  end

  assign last = run && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opb_q    <= '0;
      a_raw_q  <= '0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      a_raw_q  <= a_raw_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
    end
  end

endmodule

// File: rtl/alu_mdu_ctrl.sv
// alu_mdu_ctrl: MIPS-style ALU control decode, single-cycle ALU, HI/LO
// registers and the IDLE/MUL/DIV sequencer around mdu_iter.
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request; alu_op/funct/a/b sampled with it
//   alu_op, funct     operation select
//   a, b              operands (rs, rt)
//   busy              multiply/divide in progress
//   done              one-cycle pulse, result/zero/ovf valid
//   result, zero, ovf registered outputs
//   ctrl              combinational decoded operation code
//   dbg_state         current sequencer state (state_e encoding)
//
// Handshake: start is sampled on a rising edge only while busy=0 and is
// ignored otherwise. Single-cycle ops raise done right after the accepting
// edge; multiply/divide raise busy after it and done WIDTH edges later, in
// the same cycle busy drops. done is never held for more than one cycle.
module alu_mdu_ctrl
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic [3:0]       ctrl,
  output logic [1:0]       dbg_state
);
  state_e           state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d, zero_q, zero_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;

  ctrl_e            op_c;
  logic             is_mul, is_div, mdu_load, mdu_last, signed_add, signed_sub, alu_ovf;
  logic [WIDTH-1:0] sum, diff, alu_res, mdu_hi, mdu_lo;

  always_comb begin
    op_c   = decode_ctrl(alu_op, funct);
    is_mul = (op_c == CTRL_MULT) || (op_c == CTRL_MULTU);
    is_div = (op_c == CTRL_DIV)  || (op_c == CTRL_DIVU);
  end

  assign ctrl      = op_c;
  assign dbg_state = state_q;
  assign mdu_load  = start && (state_q == S_IDLE) && (is_mul || is_div);

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (mdu_load),
    .run       (state_q != S_IDLE),
    .is_div    (is_div),
    .is_signed ((op_c == CTRL_MULT) || (op_c == CTRL_DIV)),
    .a         (a),
    .b         (b),
    .last      (mdu_last),
    .hi        (mdu_hi),
    .lo        (mdu_lo)
  );

  // Overflow is reported only for the signed add/sub encodings, not ADDU/SUBU.
  always_comb begin
    sum        = a + b;
    diff       = a - b;
    signed_add = (alu_op == 2'b00) || ((alu_op == 2'b10) && (funct == F_ADD));
    signed_sub = (alu_op == 2'b01) || ((alu_op == 2'b10) && (funct == F_SUB));
    alu_res    = '0;
    alu_ovf    = 1'b0;
    case (op_c)
      CTRL_ADD: begin
        alu_res = sum;
        alu_ovf = signed_add && (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      CTRL_SUB: begin
        alu_res = diff;
        alu_ovf = signed_sub && (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      CTRL_AND:  alu_res = a & b;
      CTRL_OR:   alu_res = a | b;
      CTRL_XOR:  alu_res = a ^ b;
      CTRL_NOR:  alu_res = ~(a | b);
      CTRL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      CTRL_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      CTRL_MFHI: alu_res = hi_q;
      CTRL_MFLO: alu_res = lo_q;
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_mul) begin
            state_d = S_MUL;
          end else if (is_div) begin
            state_d = S_DIV;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            done_d   = 1'b1;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (mdu_last) begin
          state_d  = S_IDLE;
          hi_d     = mdu_hi;
          lo_d     = mdu_lo;
          result_d = mdu_lo;
          zero_d   = (mdu_lo == '0);
          ovf_d    = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
module tb_alu_mdu_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, start, busy, done, zero, ovf;
  logic [1:0]   alu_op, dbg_state;
  logic [5:0]   funct;
  logic [W-1:0] a, b, result;
  logic [3:0]   ctrl;

  int checks   = 0;
  int failures = 0;

  // Expected {result, zero, ovf} per done pulse, with a name per entry.
  logic [W+1:0] exp_q[$];
  string        tag_q[$];

  alu_mdu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .funct(funct),
    .a(a), .b(b), .busy(busy), .done(done), .result(result), .zero(zero),
    .ovf(ovf), .ctrl(ctrl), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done got result=%0h expected no done", result);
      end else begin
        logic [W+1:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, 64'({result, zero, ovf}), 64'(e));
      end
    end
  end

  // Expected ctrl code, written from the funct table.
  function automatic logic [3:0] ctrl_model(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0000;
    case (f)
      6'b100000, 6'b100001: return 4'b0010;
      6'b100010, 6'b100011: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100110: return 4'b0011;
      6'b100111: return 4'b1100;
      6'b101010: return 4'b0111;
      6'b101011: return 4'b1000;
      6'b011000: return 4'b1001;
      6'b011001: return 4'b1010;
      6'b011010: return 4'b1011;
      6'b011011: return 4'b1101;
      6'b010000: return 4'b1110;
      6'b010010: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Issues one op, scrambles the inputs after acceptance, pokes start while
  // busy, and checks done latency and busy duration.
  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] er, input logic eo,
                       input int exp_lat, input string tag);
    int lat;
    int busy_n;
    exp_q.push_back({er, (er == '0), eo});
    tag_q.push_back(tag);
    @(negedge clk);
    alu_op = op; funct = fn; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    funct  = 6'($urandom_range(0, 63));
    alu_op = 2'($urandom_range(0, 3));
    lat    = 1;
    busy_n = 0;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      start = (lat == 5);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
  endtask

  task automatic alu(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] av,
                     input logic [W-1:0] bv, input logic [W-1:0] er, input logic eo, input string tag);
    issue(op, fn, av, bv, er, eo, 1, tag);
  endtask

  task automatic mdu(input logic [5:0] fn, input logic [W-1:0] av, input logic [W-1:0] bv,
                     input logic [W-1:0] er, input string tag);
    issue(2'b10, fn, av, bv, er, 1'b0, W + 1, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    start = 1'b0; alu_op = 2'b00; funct = 6'd0; a = '0; b = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_zero", 64'(zero), 64'(1));
    check("rst_ovf", 64'(ovf), 64'(0));
    @(posedge clk); #2 rst_n = 1'b1;

    // Single-cycle ALU
    alu(2'b10, 6'b100010, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, "sub_5_7");
    alu(2'b00, 6'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, "add_ovf");
    alu(2'b10, 6'b100001, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, "addu_no_ovf");
    alu(2'b01, 6'd0, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, "sub_ovf");
    alu(2'b10, 6'b100011, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, "subu_no_ovf");
    alu(2'b00, 6'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, "add_zero");
    alu(2'b10, 6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, "and");
    alu(2'b10, 6'b100101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, "or");
    alu(2'b10, 6'b100110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, "xor");
    alu(2'b10, 6'b100111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, "nor");
    alu(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, "slt");
    alu(2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, "sltu");
    alu(2'b11, 6'b100000, 32'h0F0F_0F0F, 32'hFFFF_0000, 32'h0F0F_0000, 1'b0, "aluop11_and");
    alu(2'b10, 6'b000000, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_5678, 1'b0, "undef_funct_and");

    // Multiply / divide, each followed by HI readback
    mdu(6'b011000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, "mult_m3_7");
    alu(2'b10, 6'b010000, '0, '0, 32'hFFFF_FFFF, 1'b0, "mfhi_mult");
    alu(2'b10, 6'b010010, '0, '0, 32'hFFFF_FFEB, 1'b0, "mflo_mult");
    mdu(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "multu_max");
    alu(2'b10, 6'b010000, '0, '0, 32'hFFFF_FFFE, 1'b0, "mfhi_multu");
    mdu(6'b011000, 32'd0, 32'd5, 32'd0, "mult_zero");
    mdu(6'b011010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
    alu(2'b10, 6'b010000, '0, '0, 32'hFFFF_FFFF, 1'b0, "mfhi_div_m7_2");
    mdu(6'b011010, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2");
    alu(2'b10, 6'b010000, '0, '0, 32'd1, 1'b0, "mfhi_div_7_m2");
    mdu(6'b011011, 32'd100, 32'd7, 32'd14, "divu_100_7");
    alu(2'b10, 6'b010000, '0, '0, 32'd2, 1'b0, "mfhi_divu_100_7");
    mdu(6'b011011, 32'd9, 32'd0, 32'hFFFF_FFFF, "divu_by_zero");
    alu(2'b10, 6'b010000, '0, '0, 32'd9, 1'b0, "mfhi_divu_by_zero");
    mdu(6'b011010, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, "div_neg_by_zero");
    alu(2'b10, 6'b010000, '0, '0, 32'hFFFF_FFFB, 1'b0, "mfhi_div_neg_by_zero");
    mdu(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_min_m1");
    alu(2'b10, 6'b010000, '0, '0, 32'd0, 1'b0, "mfhi_div_min_m1");

    // Reset in the middle of a multiply: no done may follow
    @(negedge clk);
    alu_op = 2'b10; funct = 6'b011000; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("mid_busy_before_reset", 64'(busy), 64'(1));
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_result", 64'(result), 64'(0));
    check("async_rst_zero", 64'(zero), 64'(1));
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_busy", 64'(busy), 64'(0));
    alu(2'b10, 6'b010010, '0, '0, 32'd0, 1'b0, "mflo_after_reset");
    alu(2'b10, 6'b010000, '0, '0, 32'd0, 1'b0, "mfhi_after_reset");

    // ctrl decode sweep
    @(negedge clk);
    for (int f = 0; f < 64; f++) begin
      alu_op = 2'b10;
      funct  = 6'(f);
      #1;
      check($sformatf("ctrl_funct_%02h", f), 64'(ctrl), 64'(ctrl_model(2'b10, 6'(f))));
    end
    for (int op = 0; op < 4; op += 1) begin
      if (op == 2) continue;
      alu_op = 2'(op);
      funct  = 6'($urandom_range(0, 63));
      #1;
      check($sformatf("ctrl_aluop_%0d", op), 64'(ctrl), 64'(ctrl_model(2'(op), funct)));
    end

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mdu_ctrl.md
ALU_MDU_CTRL -- requirements
Module: alu_mdu_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal values are even and >= 8.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  operation request, sampled on clk when busy=0.
REQ-005 alu_op  input  2  00 add, 01 sub, 10 decode funct, 11 reserved.
REQ-006 funct  input  6  MIPS R-type function field.
REQ-007 a, b  input  WIDTH each  operands (rs, rt).
REQ-008 busy  output  1  multi-cycle operation in progress.
REQ-009 done  output  1  one-cycle pulse, result valid.
REQ-010 result  output  WIDTH  registered result.
REQ-011 zero  output  1  result == 0, registered with result.
REQ-012 ovf  output  1  signed overflow, add/sub only.
REQ-013 ctrl  output  4  combinational decoded operation code.

Function
REQ-014 Decode: alu_op 00 gives ADD 0010; 01 gives SUB 0110; 11 gives AND 0000.
REQ-015 Decode for alu_op 10, by funct:
- 100000/100001 ADD 0010
- 100010/100011 SUB 0110
- 100100 AND 0000
- 100101 OR 0001
- 100110 XOR 0011
- 100111 NOR 1100
- 101010 SLT 0111
- 101011 SLTU 1000
- 011000 MULT 1001
- 011001 MULTU 1010
- 011010 DIV 1011
- 011011 DIVU 1101
- 010000 MFHI 1110
- 010010 MFLO 1111
- any other funct: AND 0000.
REQ-016 Single-cycle ops (all except the four MDU ops): start accepted at edge N gives result/zero/ovf registered and done=1 after edge N; busy stays 0.
REQ-017 ovf=1 only for signed add (alu_op 00, funct 100000) or signed sub (alu_op 01, funct 100010) when the signed result overflows; 0 otherwise; result is still written.
REQ-018 SLT/SLTU give result 1 or 0, zero-extended to WIDTH.
REQ-019 FSM states: IDLE, MUL, DIV. Start with an MDU op moves IDLE to MUL or DIV at edge N, with busy=1 from after edge N.
REQ-020 MUL: radix-2 shift-add over WIDTH cycles. DIV: restoring shift-subtract over WIDTH cycles. Both operate on operand magnitudes; the signed variants apply sign correction.
REQ-021 After edge N+WIDTH the FSM returns to IDLE, busy=0, and done=1 for one cycle. HI/LO are updated at that edge, and result=LO.
REQ-022 Mult: {HI,LO} = full 2*WIDTH product.
REQ-023 Div: LO = quotient, truncated toward zero; HI = remainder, carrying the sign of the dividend.
REQ-024 Divide by zero: LO = all ones, HI = a. No error flag is raised.
REQ-025 Signed div of the most-negative value by -1: LO = most-negative value, HI = 0.
REQ-026 MFHI/MFLO are single-cycle and return current HI/LO. They are not blocked by a completed MDU op.
REQ-027 start while busy=1 is ignored: no state change, no done.
REQ-028 Operands are latched at acceptance; later changes to a/b/funct do not affect an in-flight MDU op.
REQ-029 done=0 in every cycle not covered by REQ-016/REQ-021.

Reset
REQ-030 rst_n low asynchronously forces IDLE, busy=0, done=0, result=0, zero=1, ovf=0, HI=0, LO=0.
REQ-031 Reset during MUL/DIV aborts the operation; no done follows deassertion.
REQ-032 The first start is accepted at the first clk edge after rst_n deassertion.

Structure
REQ-033 Package alu_mdu_pkg holds the ctrl code enum (4-bit), the funct constants, and the FSM state enum.
REQ-034 One sub-module, mdu_iter, contains the iterative multiply/divide datapath and counter. Decode, the single-cycle ALU and the HI/LO registers stay in alu_mdu_ctrl.

Verification
REQ-035 alu_op=10, funct=100010, a=5, b=7, start -> next cycle: done=1, result=0xFFFFFFFE, zero=0, ovf=0.
REQ-036 alu_op=00, a=0x7FFFFFFF, b=1 -> result=0x80000000, ovf=1. Same operands with funct 100001 via alu_op=10 -> ovf=0.
REQ-037 MULT a=-3, b=7 -> busy=1 for 32 cycles, done at cycle 33 with result=0xFFFFFFEB; then MFHI -> 0xFFFFFFFF.
REQ-038 DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=9, b=0 -> LO=0xFFFFFFFF, HI=9.
REQ-039 Start during busy, plus rst_n pulsed mid-MULT -> no extra done; after reset, MFLO returns 0.
REQ-040 Sweep of all 64 funct values with alu_op=10 -> ctrl matches REQ-015; undefined values give 0000.
